echo_tof_extract: RTL and testbench

//  Downstream of the 400-sample echo capture stage. On each capture-done strobe it latches the
//  400-bit echo vector and scans it one 16-bit word per clock. It reports the first echo pulse:

---
 rtl/echo_tof_extract_if.sv | 32 +++
 rtl/echo_tof_extract.sv | 218 +++++++++++++++++++++
 tb/tb_echo_tof_extract.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_tof_extract_if.sv
// Bus between the echo capture stage (master) and the time-of-flight extractor (slave).
// Carries the captured echo vector with its strobe, and the per-shot result back.
interface echo_tof_extract_if #(
    parameter int NWORDS = 25,
    parameter int WORD_W = 16
);
    localparam int NBITS = NWORDS * WORD_W;
    localparam int TW    = $clog2(NBITS);

    logic [NBITS-1:0] total_data;
    logic             tola_en;
    logic             busy;
    logic             echo_valid;
    logic [TW-1:0]    echo_rise;
    logic [TW-1:0]    echo_width;
    logic             echo_none;
    logic             echo_trunc;
    logic             echo_short;
    logic [7:0]       drop_cnt;

    modport master (
        output total_data, tola_en,
        input  busy, echo_valid, echo_rise, echo_width,
               echo_none, echo_trunc, echo_short, drop_cnt
    );

    modport slave (
        input  total_data, tola_en,
        output busy, echo_valid, echo_rise, echo_width,
               echo_none, echo_trunc, echo_short, drop_cnt
    );
endinterface

// File: rtl/echo_tof_extract.sv
// Latches one captured echo vector per shot and scans it a word per clock to find the
// first accepted pulse: rise index, width and status flags, with a fixed result latency.
module echo_tof_extract #(
    parameter int NWORDS    = 25,
    parameter int WORD_W    = 16,
    parameter int BLANK_IDX = 4,
    parameter int MIN_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    echo_tof_extract_if.slave bus
);
    localparam int NBITS = NWORDS * WORD_W;
    localparam int TW    = $clog2(NBITS);
    localparam int BW    = $clog2(WORD_W);
    localparam int WCW   = $clog2(NWORDS);
    localparam logic [TW-1:0]  NBITS_T = TW'(NBITS);
    localparam logic [WCW-1:0] LAST_W  = WCW'(NWORDS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
    typedef enum logic [1:0] {SUB_FIND_RISE, SUB_FIND_FALL, SUB_FOUND} sub_t;

    state_t           state_q, state_d;
    sub_t             sub_q, sub_d;
    logic [NBITS-1:0] data_q, data_d;
    logic [WCW-1:0]   word_q, word_d;
    logic             prev_q, prev_d;
    logic [TW-1:0]    rise_idx_q, rise_idx_d;
    logic [TW-1:0]    fall_idx_q, fall_idx_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [TW-1:0]    rise_out_q, rise_out_d;
    logic [TW-1:0]    width_out_q, width_out_d;
    logic             none_q, none_d;
    logic             trunc_q, trunc_d;
    logic             short_q, short_d;
    logic [7:0]       drop_q, drop_d;

    logic [TW-1:0]     word_base;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] prev_vec;
    logic [WORD_W-1:0] rise_raw;
    logic [WORD_W-1:0] rise_mask;
    logic [WORD_W-1:0] fall_mask;
    logic [WORD_W-1:0] keep_mask;
    logic [WORD_W-1:0] gt_mask;
    logic              rise_hit, fall_hit, fall_gt_hit;
    logic [BW-1:0]     rise_pos, fall_pos, fall_gt_pos;
    logic              last_word;
    logic              none_calc, trunc_calc;
    logic [TW-1:0]     width_calc;

    // Returns {found, index of lowest set bit}.
    function automatic logic [BW:0] lowest_set(input logic [WORD_W-1:0] v);
        logic [BW:0] res;
        res = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                res = {1'b1, BW'(i)};
            end
        end
        return res;
    endfunction

    assign word_base = TW'(word_q) * TW'(WORD_W);
    assign cur_word  = data_q[word_base +: WORD_W];
    // Bit 0's predecessor is the last sample of the previous word.
    assign prev_vec  = {cur_word[WORD_W-2:0], prev_q};
    assign rise_raw  = cur_word & ~prev_vec;
    assign fall_mask = ~cur_word & prev_vec;
    assign rise_mask = rise_raw & keep_mask;
    assign last_word = (word_q == LAST_W);

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
            assign keep_mask[gi] = (word_base + TW'(gi)) >= TW'(BLANK_IDX);
            assign gt_mask[gi]   = BW'(gi) > rise_pos;
        end
    endgenerate

    assign {rise_hit, rise_pos}       = lowest_set(rise_mask);
    assign {fall_hit, fall_pos}       = lowest_set(fall_mask);
    assign {fall_gt_hit, fall_gt_pos} = lowest_set(fall_mask & gt_mask);

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        data_d      = data_q;
        word_d      = word_q;
        prev_d      = prev_q;
        rise_idx_d  = rise_idx_q;
        fall_idx_d  = fall_idx_q;
        valid_d     = 1'b0;
        rise_out_d  = rise_out_q;
        width_out_d = width_out_q;
        none_d      = none_q;
        trunc_d     = trunc_q;
        short_d     = short_q;
        drop_d      = drop_q;
        none_calc   = 1'b0;
        trunc_calc  = 1'b0;
        width_calc  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.tola_en) begin
                    data_d     = bus.total_data;
                    word_d     = '0;
                    prev_d     = 1'b0;
                    sub_d      = SUB_FIND_RISE;
                    rise_idx_d = '0;
                    fall_idx_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                prev_d = cur_word[WORD_W-1];
                word_d = word_q + 1'b1;
                case (sub_q)
                    SUB_FIND_RISE: begin
                        if (rise_hit) begin
                            rise_idx_d = word_base + TW'(rise_pos);
                            if (fall_gt_hit) begin
                                fall_idx_d = word_base + TW'(fall_gt_pos);
                                sub_d      = SUB_FOUND;
                            end else begin
                                sub_d = SUB_FIND_FALL;
                            end
                        end
                    end
                    SUB_FIND_FALL: begin
                        if (fall_hit) begin
                            fall_idx_d = word_base + TW'(fall_pos);
                            sub_d      = SUB_FOUND;
                        end
                    end
                    default: ;
                endcase
                if (last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Final classification uses the sub-state after the last word has been applied.
        none_calc  = (sub_d == SUB_FIND_RISE);
        trunc_calc = (sub_d == SUB_FIND_FALL);
        if (none_calc) begin
            width_calc = '0;
        end else if (trunc_calc) begin
            width_calc = NBITS_T - rise_idx_d;
        end else begin
            width_calc = fall_idx_d - rise_idx_d;
        end

        if (state_q == ST_SCAN && last_word) begin
            valid_d     = 1'b1;
            rise_out_d  = none_calc ? '0 : rise_idx_d;
            width_out_d = width_calc;
            none_d      = none_calc;
            trunc_d     = trunc_calc;
            short_d     = ~none_calc & (width_calc < TW'(MIN_WIDTH));
        end

        if (bus.tola_en && state_q != ST_IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sub_q       <= SUB_FIND_RISE;
            data_q      <= '0;
            word_q      <= '0;
            prev_q      <= 1'b0;
            rise_idx_q  <= '0;
            fall_idx_q  <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            rise_out_q  <= '0;
            width_out_q <= '0;
            none_q      <= 1'b0;
            trunc_q     <= 1'b0;
            short_q     <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            data_q      <= data_d;
            word_q      <= word_d;
            prev_q      <= prev_d;
            rise_idx_q  <= rise_idx_d;
            fall_idx_q  <= fall_idx_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            rise_out_q  <= rise_out_d;
            width_out_q <= width_out_d;
            none_q      <= none_d;
            trunc_q     <= trunc_d;
            short_q     <= short_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.echo_valid = valid_q;
    assign bus.echo_rise  = rise_out_q;
    assign bus.echo_width = width_out_q;
    assign bus.echo_none  = none_q;
    assign bus.echo_trunc = trunc_q;
    assign bus.echo_short = short_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_echo_tof_extract.sv
// Directed bench for echo_tof_extract: one task per scenario, hand-computed expectations.
module tb_echo_tof_extract;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    echo_tof_extract_if bus();
    echo_tof_extract dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [399:0] span(input int lo, input int hi);
        logic [399:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [20:0] result_tuple();
        return {bus.echo_rise, bus.echo_width, bus.echo_none, bus.echo_trunc, bus.echo_short};
    endfunction

    // Strobe one shot and wait (bounded) for echo_valid; lat = cycles after the strobe cycle, -1 on timeout.
    task automatic run_shot(input logic [399:0] v, output int lat);
        @(negedge clk);
        bus.total_data = v;
        bus.tola_en    = 1'b1;
        @(negedge clk);
        bus.tola_en    = 1'b0;
        bus.total_data = ~v;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.echo_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.tola_en    = 1'b0;
        bus.total_data = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.echo_valid, result_tuple(), bus.drop_cnt} !== 31'd0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b valid=%b tuple=%h drop=%0d exp all zero",
                     bus.busy, bus.echo_valid, result_tuple(), bus.drop_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        int busy_bad;
        logic [20:0] res;
        lat = -1;
        busy_bad = 0;
        res = '0;
        @(negedge clk);
        bus.total_data = span(100, 109);
        bus.tola_en    = 1'b1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy_before got=%b exp=0", bus.busy);
        end
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.tola_en    = 1'b0;
                bus.total_data = '0;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.echo_valid === 1'b1 && lat < 0) lat = k;
            if (k == 26) res = result_tuple();
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_err++;
            $display("FAIL basic_busy_window got=%0d low cycles exp=0", busy_bad);
        end
        n_cmp++;
        if (lat != 26) begin
            n_err++;
            $display("FAIL basic_latency got=%0d exp=26", lat);
        end
        n_cmp++;
        if (res !== {9'd100, 9'd10, 3'b000}) begin
            n_err++;
            $display("FAIL basic_result got rise=%0d width=%0d flags=%b exp rise=100 width=10 flags=000",
                     res[20:12], res[11:3], res[2:0]);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.echo_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_after_done got busy=%b valid=%b exp 0 0", bus.busy, bus.echo_valid);
        end
        n_cmp++;
        if (result_tuple() !== {9'd100, 9'd10, 3'b000}) begin
            n_err++;
            $display("FAIL basic_hold got tuple=%h exp rise=100 width=10", result_tuple());
        end
    endtask

    task automatic test_no_echo();
        logic [399:0] vecs [3];
        logic [20:0]  exps [3];
        int lat;
        vecs[0] = '0;            exps[0] = {9'd0, 9'd0, 3'b100};
        vecs[1] = span(0, 2);    exps[1] = {9'd0, 9'd0, 3'b100};
        vecs[2] = span(4, 6);    exps[2] = {9'd4, 9'd3, 3'b000};
        for (int i = 0; i < 3; i++) begin
            run_shot(vecs[i], lat);
            n_cmp++;
            if (lat != 26) begin
                n_err++;
                $display("FAIL none_latency[%0d] got=%0d exp=26", i, lat);
            end
            n_cmp++;
            if (result_tuple() !== exps[i]) begin
                n_err++;
                $display("FAIL none_result[%0d] got rise=%0d width=%0d flags=%b exp rise=%0d width=%0d flags=%b",
                         i, bus.echo_rise, bus.echo_width, result_tuple() & 21'h7,
                         exps[i][20:12], exps[i][11:3], exps[i][2:0]);
            end
        end
    endtask

    task automatic test_short_and_trunc();
        logic [399:0] vecs [3];
        logic [20:0]  exps [3];
        int lat;
        vecs[0] = span(30, 31) | span(200, 399); exps[0] = {9'd30,  9'd2, 3'b001};
        vecs[1] = span(392, 399);                exps[1] = {9'd392, 9'd8, 3'b010};
        vecs[2] = span(399, 399);                exps[2] = {9'd399, 9'd1, 3'b011};
        for (int i = 0; i < 3; i++) begin
            run_shot(vecs[i], lat);
            n_cmp++;
            if (lat != 26 || result_tuple() !== exps[i]) begin
                n_err++;
                $display("FAIL short_trunc[%0d] got lat=%0d rise=%0d width=%0d flags=%b exp lat=26 rise=%0d width=%0d flags=%b",
                         i, lat, bus.echo_rise, bus.echo_width, result_tuple() & 21'h7,
                         exps[i][20:12], exps[i][11:3], exps[i][2:0]);
            end
        end
    endtask

    task automatic test_word_boundary();
        logic [399:0] vecs [2];
        logic [20:0]  exps [2];
        int lat;
        vecs[0] = span(15, 16); exps[0] = {9'd15, 9'd2,  3'b001};
        vecs[1] = span(16, 31); exps[1] = {9'd16, 9'd16, 3'b000};
        for (int i = 0; i < 2; i++) begin
            run_shot(vecs[i], lat);
            n_cmp++;
            if (lat != 26 || result_tuple() !== exps[i]) begin
                n_err++;
                $display("FAIL boundary[%0d] got lat=%0d rise=%0d width=%0d flags=%b exp lat=26 rise=%0d width=%0d flags=%b",
                         i, lat, bus.echo_rise, bus.echo_width, result_tuple() & 21'h7,
                         exps[i][20:12], exps[i][11:3], exps[i][2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int valid_cnt;
        valid_cnt = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k >= 1 && bus.echo_valid === 1'b1) valid_cnt++;
            if (k == 26) begin
                n_cmp++;
                if ({bus.echo_valid, bus.echo_rise} !== {1'b1, 9'd100}) begin
                    n_err++;
                    $display("FAIL b2b_first got valid=%b rise=%0d exp valid=1 rise=100",
                             bus.echo_valid, bus.echo_rise);
                end
            end
            if (k == 53) begin
                n_cmp++;
                if ({bus.echo_valid, result_tuple()} !== {1'b1, 9'd200, 9'd4, 3'b000}) begin
                    n_err++;
                    $display("FAIL b2b_second got valid=%b rise=%0d width=%0d exp valid=1 rise=200 width=4",
                             bus.echo_valid, bus.echo_rise, bus.echo_width);
                end
                n_cmp++;
                if (bus.drop_cnt !== 8'd2) begin
                    n_err++;
                    $display("FAIL b2b_drop_cnt got=%0d exp=2", bus.drop_cnt);
                end
            end
            bus.tola_en = (k == 0 || k == 5 || k == 26 || k == 27);
            if (k == 0)       bus.total_data = span(100, 109);
            else if (k == 27) bus.total_data = span(200, 203);
            else              bus.total_data = span(50, 59);
        end
        n_cmp++;
        if (valid_cnt != 2) begin
            n_err++;
            $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        int valid_cnt;
        int lat;
        valid_cnt = 0;
        @(negedge clk);
        bus.total_data = span(100, 109);
        bus.tola_en    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.tola_en = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.echo_valid, result_tuple(), bus.drop_cnt} !== 31'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got busy=%b valid=%b tuple=%h drop=%0d exp all zero",
                     bus.busy, bus.echo_valid, result_tuple(), bus.drop_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.echo_valid === 1'b1) valid_cnt++;
        end
        n_cmp++;
        if (valid_cnt != 0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_result got valids=%0d busy=%b exp valids=0 busy=0", valid_cnt, bus.busy);
        end
        run_shot(span(100, 109), lat);
        n_cmp++;
        if (lat != 26 || result_tuple() !== {9'd100, 9'd10, 3'b000}) begin
            n_err++;
            $display("FAIL midreset_recover got lat=%0d rise=%0d width=%0d exp lat=26 rise=100 width=10",
                     lat, bus.echo_rise, bus.echo_width);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_echo();
        test_short_and_trunc();
        test_word_boundary();
        test_back_to_back();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
